// File: rtl/din_row_packer_pkg.sv
// Shared types and constants for the din_row_packer slice: FSM state encoding,
// default geometry and the packed-row width helper.
package din_row_packer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  localparam int DWIDTH_DEF = 16;
  localparam int PE_ROW_DEF = 12;
  localparam int AWIDTH_DEF = 6;

  function automatic int row_width(input int dwidth, input int pe_row);
    return dwidth * pe_row;
  endfunction

endpackage

// File: rtl/din_row_packer_if.sv
// Bundle of config, stream and row-read signals for din_row_packer.
// drop_cnt exists only when DIN_ROW_PACKER_DROP_CNT_EN is defined.
interface din_row_packer_if
  import din_row_packer_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int PE_ROW = PE_ROW_DEF,
  parameter int AWIDTH = AWIDTH_DEF
);
  localparam int RWIDTH = row_width(DWIDTH, PE_ROW);

  logic              cfg_valid;
  logic [AWIDTH:0]   cfg_rows;
  logic              cfg_busy;
  logic              din_valid;
  logic [DWIDTH-1:0] din_data;
  logic              done;
  logic              outside_memory_rreq;
  logic [AWIDTH-1:0] outside_memory_addr;
  logic [RWIDTH-1:0] outside_memory_dout;
  logic              outside_memory_dvalid;
`ifdef DIN_ROW_PACKER_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output cfg_valid, cfg_rows, din_valid, din_data,
    output outside_memory_rreq, outside_memory_addr,
    input  cfg_busy, done, outside_memory_dout, outside_memory_dvalid
`ifdef DIN_ROW_PACKER_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  cfg_valid, cfg_rows, din_valid, din_data,
    input  outside_memory_rreq, outside_memory_addr,
    output cfg_busy, done, outside_memory_dout, outside_memory_dvalid
`ifdef DIN_ROW_PACKER_DROP_CNT_EN
    , output drop_cnt
`endif
  );

endinterface

// File: rtl/din_row_packer_row_buffer_ram.sv
// Simple dual-port row buffer: one write port, one registered read port.
// A same-address read and write at one edge returns the previous contents.
module row_buffer_ram
  import din_row_packer_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int RWIDTH = row_width(DWIDTH_DEF, PE_ROW_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [RWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [RWIDTH-1:0] rdata,
  output logic              rvalid
);

  logic [RWIDTH-1:0] mem [2**AWIDTH];

  // Storage is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/din_row_packer.sv
// Packs PE_ROW consecutive stream words into one row and stores N rows in a
// row buffer read out row-wide. Optional drop counter: DIN_ROW_PACKER_DROP_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for cfg_valid; stream beats are dropped
// CAPTURE | packing words into rows until the requested row count is written
module din_row_packer
  import din_row_packer_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int PE_ROW = PE_ROW_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input logic            clk,
  input logic            rst,
  din_row_packer_if.slave bus
);

  localparam int RWIDTH = row_width(DWIDTH, PE_ROW);
  localparam int WCW    = $clog2(PE_ROW);
  localparam int RCW    = AWIDTH + 1;
  localparam logic [RCW-1:0] MAX_ROWS  = RCW'(1 << AWIDTH);
  localparam logic [WCW-1:0] LAST_LANE = WCW'(PE_ROW - 1);

  state_t            state;
  logic              cfg_busy_q;
  logic              done_q;
  logic [WCW-1:0]    word_cnt;
  logic [RCW-1:0]    row_cnt;
  logic [RCW-1:0]    rows;
  logic [RCW-1:0]    row_cnt_nxt;
  logic [DWIDTH-1:0] lanes [PE_ROW-1];
  logic [RWIDTH-1:0] wr_row;
  logic              accept;
  logic              row_end;

  assign accept      = (state == CAPTURE) && bus.din_valid;
  assign row_end     = accept && (word_cnt == LAST_LANE);
  assign row_cnt_nxt = row_cnt + RCW'(1);

  // The last lane comes straight from the input so the row lands on its final beat.
  always_comb begin
    wr_row = '0;
    for (int i = 0; i < PE_ROW - 1; i++) begin
      wr_row[i*DWIDTH +: DWIDTH] = lanes[i];
    end
    wr_row[(PE_ROW-1)*DWIDTH +: DWIDTH] = bus.din_data;
  end

  // Words enter at the top and drift down, so after PE_ROW-1 beats lane 0 holds the oldest.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < PE_ROW - 2; i++) begin
        lanes[i] <= lanes[i+1];
      end
      lanes[PE_ROW-2] <= bus.din_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cfg_busy_q <= 1'b0;
      done_q     <= 1'b0;
      word_cnt   <= '0;
      row_cnt    <= '0;
      rows       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            if (bus.cfg_rows != '0) begin
              rows       <= (bus.cfg_rows > MAX_ROWS) ? MAX_ROWS : bus.cfg_rows;
              word_cnt   <= '0;
              row_cnt    <= '0;
              cfg_busy_q <= 1'b1;
              state      <= CAPTURE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (row_end) begin
            word_cnt <= '0;
            row_cnt  <= row_cnt_nxt;
            if (row_cnt_nxt == rows) begin
              done_q     <= 1'b1;
              cfg_busy_q <= 1'b0;
              state      <= IDLE;
            end
          end else if (accept) begin
            word_cnt <= word_cnt + WCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_busy = cfg_busy_q;
  assign bus.done     = done_q;

`ifdef DIN_ROW_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // A beat coincident with an accepted cfg_valid is discarded without counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (state == IDLE) begin
      if (bus.cfg_valid) begin
        drop_cnt <= '0;
      end else if (bus.din_valid && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign bus.drop_cnt = drop_cnt;
`endif

  row_buffer_ram #(
    .AWIDTH (AWIDTH),
    .RWIDTH (RWIDTH)
  ) u_row_buffer_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (row_end),
    .waddr  (row_cnt[AWIDTH-1:0]),
    .wdata  (wr_row),
    .re     (bus.outside_memory_rreq),
    .raddr  (bus.outside_memory_addr),
    .rdata  (bus.outside_memory_dout),
    .rvalid (bus.outside_memory_dvalid)
  );

endmodule

// File: tb/tb_din_row_packer.sv
// Self-checking bench for din_row_packer: a word-queue reference model builds
// the expected row buffer from the stream and every read is checked against it.
module tb_din_row_packer;

  localparam int DW    = 16;
  localparam int PR    = 12;
  localparam int AW    = 6;
  localparam int RW    = DW * PR;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  din_row_packer_if #(.DWIDTH(DW), .PE_ROW(PR), .AWIDTH(AW)) bus ();

  din_row_packer #(.DWIDTH(DW), .PE_ROW(PR), .AWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] stim [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] pack_words(input logic [DW-1:0] w [$]);
    logic [RW-1:0] r;
    r = '0;
    foreach (w[i]) r[i*DW +: DW] = w[i];
    return r;
  endfunction

  task automatic fill_seq(input int base, input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'(base + i));
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'($urandom));
  endtask

  task automatic read_row(input int a, input bit hold);
    bus.outside_memory_rreq = 1'b1;
    bus.outside_memory_addr = AW'(a);
    tick();
    bus.outside_memory_rreq = 1'b0;
    n_tests++;
    if (bus.outside_memory_dvalid !== 1'b1 || bus.outside_memory_dout !== exp_mem[a]) begin
      n_fail++;
      $display("FAIL read_row[%0d]: dvalid=%b dout=%h, expected dvalid=1 dout=%h",
               a, bus.outside_memory_dvalid, bus.outside_memory_dout, exp_mem[a]);
    end
    if (hold) begin
      bus.outside_memory_addr = AW'(a + 1);
      tick();
      n_tests++;
      if (bus.outside_memory_dvalid !== 1'b0 || bus.outside_memory_dout !== exp_mem[a]) begin
        n_fail++;
        $display("FAIL read_hold[%0d]: dvalid=%b dout=%h, expected dvalid=0 dout=%h",
                 a, bus.outside_memory_dvalid, bus.outside_memory_dout, exp_mem[a]);
      end
    end
  endtask

  // gap: 0 = random valid, n = one valid beat every n cycles.
  task automatic capture(input int req_rows, input int gap, input bit inject_cfg, input bit collide);
    int eff, total, sent, cycles, cur_row;
    bit bad_mid, did_collide, fire;
    logic [RW-1:0] old_row;
    logic [DW-1:0] rowq [$];
    eff   = (req_rows > DEPTH) ? DEPTH : req_rows;
    total = eff * PR;
    bus.cfg_valid = 1'b1;
    bus.cfg_rows  = (AW+1)'(req_rows);
    bus.din_valid = 1'b1;
    bus.din_data  = 16'hDEAD;
    tick();
    bus.cfg_valid = 1'b0;
    bus.din_valid = 1'b0;
    n_tests++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_busy_on: got %b expected 1", bus.cfg_busy);
    end
    sent = 0; cycles = 0; cur_row = 0; bad_mid = 0; did_collide = 0; old_row = '0;
    while (sent < total && cycles < 4 * total + 100) begin
      if (inject_cfg && sent == PR / 2) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_rows  = (AW+1)'(3);
      end
      fire = (gap == 0) ? ($urandom_range(0, 1) == 1) : ((cycles % gap) == 0);
      if (fire) begin
        bus.din_valid = 1'b1;
        bus.din_data  = stim[sent];
        rowq.push_back(stim[sent]);
        sent++;
        if (rowq.size() == PR) begin
          if (collide && sent == total) begin
            bus.outside_memory_rreq = 1'b1;
            bus.outside_memory_addr = AW'(cur_row);
            old_row     = exp_mem[cur_row];
            did_collide = 1'b1;
          end
          exp_mem[cur_row] = pack_words(rowq);
          cur_row++;
          rowq.delete();
        end
      end
      tick();
      bus.din_valid = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.outside_memory_rreq = 1'b0;
      if (sent < total && (bus.done !== 1'b0 || bus.cfg_busy !== 1'b1)) bad_mid = 1'b1;
      cycles++;
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_at_last_word (rows=%0d): done=%b busy=%b, expected done=1 busy=0",
               req_rows, bus.done, bus.cfg_busy);
    end
    if (did_collide) begin
      n_tests++;
      if (bus.outside_memory_dvalid !== 1'b1 || bus.outside_memory_dout !== old_row) begin
        n_fail++;
        $display("FAIL collision_old_data: dout=%h expected %h", bus.outside_memory_dout, old_row);
      end
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b expected 0", bus.done);
    end
    n_tests++;
    if (bad_mid) begin
      n_fail++;
      $display("FAIL busy_done_mid_capture (rows=%0d): got early done or dropped busy, expected busy=1 done=0", req_rows);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.cfg_busy !== 1'b0 || bus.done !== 1'b0 || bus.outside_memory_dvalid !== 1'b0 ||
        bus.outside_memory_dout !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dvalid=%b dout=%h, expected all 0",
               bus.cfg_busy, bus.done, bus.outside_memory_dvalid, bus.outside_memory_dout);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fill_seq(1, 24);
    capture(2, 1, 1'b0, 1'b0);
    read_row(0, 1'b1);
    read_row(1, 1'b0);
  endtask

  task automatic test_clamp();
    fill_rand(DEPTH * PR);
    capture(100, 1, 1'b0, 1'b0);
    for (int a = 0; a < DEPTH; a++) read_row(a, 1'b0);
  endtask

  task automatic test_sparse();
    fill_seq(1, 24);
    capture(2, 3, 1'b0, 1'b0);
    read_row(0, 1'b0);
    read_row(1, 1'b0);
  endtask

  task automatic test_zero_rows();
    bus.cfg_valid = 1'b1;
    bus.cfg_rows  = '0;
    tick();
    bus.cfg_valid = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rows_done: done=%b busy=%b, expected done=1 busy=0", bus.done, bus.cfg_busy);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rows_after: done=%b busy=%b, expected 0 0", bus.done, bus.cfg_busy);
    end
  endtask

  task automatic test_drop_ignore();
    for (int i = 0; i < 5; i++) begin
      bus.din_valid = 1'b1;
      bus.din_data  = DW'($urandom);
      tick();
    end
    bus.din_valid = 1'b0;
    tick();
    read_row(0, 1'b0);
    read_row(1, 1'b0);
`ifdef DIN_ROW_PACKER_DROP_CNT_EN
    n_tests++;
    if (bus.drop_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL drop_cnt: got %0d expected 5", bus.drop_cnt);
    end
`endif
    fill_seq(16'h0200, PR);
    capture(1, 1, 1'b1, 1'b0);
    read_row(0, 1'b0);
    read_row(1, 1'b0);
  endtask

  task automatic test_reset_mid_capture();
    bus.cfg_valid = 1'b1;
    bus.cfg_rows  = (AW+1)'(1);
    tick();
    bus.cfg_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.din_valid = 1'b1;
      bus.din_data  = DW'(16'h0300 + i);
      tick();
    end
    bus.din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.cfg_busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_capture: busy=%b done=%b, expected 0 0", bus.cfg_busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    read_row(1, 1'b0);
    fill_seq(16'h0100, PR);
    capture(1, 1, 1'b0, 1'b0);
    read_row(0, 1'b1);
  endtask

  task automatic test_collision();
    fill_rand(PR);
    capture(1, 1, 1'b0, 1'b1);
    read_row(0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 4; it++) begin
      r = $urandom_range(1, 5);
      fill_rand(r * PR);
      capture(r, 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) read_row($urandom_range(0, r - 1), 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_rows  = '0;
    bus.din_valid = 1'b0;
    bus.din_data  = '0;
    bus.outside_memory_rreq = 1'b0;
    bus.outside_memory_addr = '0;
    test_reset();
    test_basic();
    test_clamp();
    test_sparse();
    test_zero_rows();
    test_drop_ignore();
    test_reset_mid_capture();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
